// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared definitions for the data-memory arbiter: the arbiter
//               state encoding and the default address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Default widths of the shared single-port data memory.
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Arbiter states: open round-robin arbitration, or memory held by a
    // locked owner.
    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of req_i at or after ptr_i, scanning upward and wrapping at
//               NUM_CORES.
// Ports       : req_i   - request vector
//               ptr_i   - index with highest priority
//               idx_o   - winning index (0 when no request)
//               valid_o - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CORES = 10,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    localparam logic [IDX_W:0] c_num = (IDX_W + 1)'(NUM_CORES);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [IDX_W:0] w_cand;

    // Scan from the farthest offset down to offset 0 so the candidate
    // closest to the pointer is the last (and therefore winning) assignment.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        w_cand  = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            w_cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (w_cand >= c_num) begin
                w_cand = w_cand - c_num;
            end
            if (req_i[w_cand[IDX_W-1:0]]) begin
                idx_o = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter sharing one single-port data memory
//               between NUM_CORES cores and a testbench load/dump port.
//               The testbench port overrides all cores. A granted core may
//               lock the memory for up to LOCK_MAX consecutive grants.
// Ports       : clk, RESET        - clock, asynchronous active-high reset
//               core_req/we/lock  - per-core request, write enable, lock
//               core_addr/wdata   - packed per-core address / write data
//               core_gnt          - one-hot grant, access happens this cycle
//               core_rvalid       - one-hot read return, cycle after grant
//               core_rdata        - read data broadcast to all cores
//               tb_en/we/addr/wdata, tb_rdata - testbench memory port
//               mem_we/addr/wdata, mem_rdata  - single-port memory side
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CORES = 10,
    parameter int ADDR_W    = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W    = dmem_arb_pkg::DATA_W,
    parameter int LOCK_MAX  = 8
) (
    input  logic                        clk,
    input  logic                        RESET,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES-1:0]        core_lock,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    input  logic                        tb_en,
    input  logic                        tb_we,
    input  logic [ADDR_W-1:0]           tb_addr,
    input  logic [DATA_W-1:0]           tb_wdata,
    output logic [DATA_W-1:0]           tb_rdata,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_CORES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(LOCK_MAX - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t        state_q,   state_d;
    logic [IDX_W-1:0]  ptr_q,     ptr_d;
    logic [IDX_W-1:0]  owner_q,   owner_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              rv_q,      rv_d;
    logic [IDX_W-1:0]  rv_idx_q,  rv_idx_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;

    logic              w_pick_vld;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_grant;
    logic [IDX_W-1:0]  w_gnt_idx;

    logic [ADDR_W-1:0] w_addr_arr  [NUM_CORES];
    logic [DATA_W-1:0] w_wdata_arr [NUM_CORES];

    // Unpack the flat per-core buses so the granted port can be indexed.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = core_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = core_wdata[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req_i   (core_req),
        .ptr_i   (ptr_q),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_vld)
    );

    // ------------------------------------------------------------------
    // Next-state and grant logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        rv_d      = 1'b0;
        rv_idx_d  = rv_idx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        w_grant   = 1'b0;
        w_gnt_idx = w_pick_idx;
        core_gnt  = '0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;

        if (RESET) begin
            // Grants are held off for as long as reset is asserted.
            state_d = ST_ARB;
        end else if (tb_en) begin
            // Testbench port owns the memory; any lock is abandoned but the
            // round-robin pointer is left where it was.
            mem_we    = tb_we;
            mem_addr  = tb_addr;
            mem_wdata = tb_wdata;
            addr_d    = tb_addr;
            wdata_d   = tb_wdata;
            state_d   = ST_ARB;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (w_pick_vld) begin
                        w_grant   = 1'b1;
                        w_gnt_idx = w_pick_idx;
                        ptr_d     = (w_pick_idx == c_idx_last) ? '0
                                                               : w_pick_idx + 1'b1;
                        if (core_lock[w_pick_idx] && (LOCK_MAX > 1)) begin
                            state_d = ST_LOCKED;
                            owner_d = w_pick_idx;
                            cnt_d   = c_cnt_one;
                        end
                    end
                end
                ST_LOCKED: begin
                    // cnt_q counts grants already taken under this lock, so
                    // the grant made at LOCK_MAX-1 is the final one.
                    w_gnt_idx = owner_q;
                    if (core_req[owner_q]) begin
                        w_grant = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == c_cnt_last) begin
                            state_d = ST_ARB;
                        end
                    end
                    if (!core_lock[owner_q]) begin
                        state_d = ST_ARB;
                    end
                end
                default: begin
                    state_d = ST_ARB;
                end
            endcase

            if (w_grant) begin
                core_gnt[w_gnt_idx] = 1'b1;
                mem_we              = core_we[w_gnt_idx];
                mem_addr            = w_addr_arr[w_gnt_idx];
                mem_wdata           = w_wdata_arr[w_gnt_idx];
                addr_d              = w_addr_arr[w_gnt_idx];
                wdata_d             = w_wdata_arr[w_gnt_idx];
                rv_d                = ~core_we[w_gnt_idx];
                rv_idx_d            = w_gnt_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_ARB;
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            rv_q     <= 1'b0;
            rv_idx_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rv_q     <= rv_d;
            rv_idx_q <= rv_idx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Read return: memory data is broadcast; rvalid marks the reader.
    // ------------------------------------------------------------------
    always_comb begin
        core_rvalid = '0;
        if (rv_q) begin
            core_rvalid[rv_idx_q] = 1'b1;
        end
    end

    assign core_rdata = mem_rdata;
    assign tb_rdata   = mem_rdata;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter: directed scenarios
//               followed by randomized traffic, all compared against a
//               behavioural model of the arbitration rules and the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int N  = 10;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LM = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            RESET;
    logic [N-1:0]    core_req, core_we, core_lock;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    core_gnt, core_rvalid;
    logic [DW-1:0]   core_rdata;
    logic            tb_en, tb_we;
    logic [AW-1:0]   tb_addr;
    logic [DW-1:0]   tb_wdata, tb_rdata;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    dmem_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .LOCK_MAX  (LM)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_lock   (core_lock),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .tb_en       (tb_en),
        .tb_we       (tb_we),
        .tb_addr     (tb_addr),
        .tb_wdata    (tb_wdata),
        .tb_rdata    (tb_rdata),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Single-port synchronous memory behind the arbiter.
    logic [DW-1:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:65535];
    int            m_ptr, m_owner, m_cnt, m_rvidx, last_win;
    bit            m_locked, m_rv, m_tbrd;
    logic [DW-1:0] m_rvdata, m_tbdata, m_last_wdata;
    logic [AW-1:0] m_last_addr;

    logic [N-1:0]  obs_gnt, obs_rvalid;
    logic [DW-1:0] obs_rdata, obs_tb_rdata, obs_wdata;
    logic [AW-1:0] obs_addr;
    logic          obs_we;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
        m_rv = 0; m_rvidx = 0; m_tbrd = 0;
        m_last_addr = '0; m_last_wdata = '0; last_win = -1;
    endtask

    // One clock of checking: compare outputs at the falling edge with the
    // model's expectation, then advance the model and step to just after
    // the next rising edge.
    task automatic cycle();
        int            win, j;
        logic [N-1:0]  eg, er;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        win = -1;
        if (!tb_en) begin
            if (m_locked) begin
                if (core_req[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (win < 0 && core_req[j]) win = j;
                end
            end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        if (tb_en) begin
            ewe = tb_we; ea = tb_addr; ed = tb_wdata;
        end else if (win >= 0) begin
            ewe = core_we[win]; ea = core_addr[win*AW +: AW]; ed = core_wdata[win*DW +: DW];
        end else begin
            ewe = 1'b0; ea = m_last_addr; ed = m_last_wdata;
        end
        er = m_rv ? onehot(m_rvidx) : '0;

        chk("core_gnt", 32'(core_gnt), 32'(eg));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_wdata", 32'(mem_wdata), 32'(ed));
        chk("core_rvalid", 32'(core_rvalid), 32'(er));
        if (m_rv) chk("core_rdata", 32'(core_rdata), 32'(m_rvdata));
        if (m_tbrd) chk("tb_rdata", 32'(tb_rdata), 32'(m_tbdata));

        obs_gnt = core_gnt; obs_rvalid = core_rvalid; obs_rdata = core_rdata;
        obs_tb_rdata = tb_rdata; obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
        last_win = win;

        // Advance the model.
        m_rv = 0; m_tbrd = 0;
        if (tb_en) begin
            m_locked = 0;
            if (tb_we) ref_mem[tb_addr] = tb_wdata;
            else begin m_tbrd = 1; m_tbdata = ref_mem[tb_addr]; end
            m_last_addr = tb_addr; m_last_wdata = tb_wdata;
        end else begin
            if (win >= 0) begin
                if (ewe) ref_mem[ea] = ed;
                else begin m_rv = 1; m_rvidx = win; m_rvdata = ref_mem[ea]; end
                m_last_addr = ea; m_last_wdata = ed;
            end
            if (m_locked) begin
                if (win >= 0) m_cnt++;
                if (!core_lock[m_owner] || (win >= 0 && m_cnt >= LM)) m_locked = 0;
            end else if (win >= 0) begin
                m_ptr = (win + 1) % N;
                if (core_lock[win] && LM > 1) begin
                    m_locked = 1; m_owner = win; m_cnt = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic req, input logic we, input logic lock,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req[i] = req; core_we[i] = we; core_lock[i] = lock;
        core_addr[i*AW +: AW] = a; core_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin ram[a] = '0; ref_mem[a] = '0; end
        RESET = 1'b1;
        core_req = '1; core_we = '0; core_lock = '0;
        core_addr = '0; core_wdata = '0;
        tb_en = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
        model_reset();

        // Reset: grants suppressed despite all requests.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 32'(core_gnt), 32'd0);
        chk("reset_rvalid", 32'(core_rvalid), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        RESET = 1'b0;

        // Round robin: all cores read continuously, core 0 first.
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 1'b0, AW'(i * 2), '0);
        for (int k = 0; k < 11; k++) begin
            cycle();
            chk("rr_gnt", 32'(obs_gnt), 32'(onehot(k % N)));
            if (k > 0) chk("rr_rvalid", 32'(obs_rvalid), 32'(onehot((k - 1) % N)));
        end
        core_req = '0;
        cycle();

        // Read return: core 3 reads 0x0040 after the tb port loads 0xBEEF.
        tb_en = 1'b1; tb_we = 1'b1; tb_addr = 16'h0040; tb_wdata = 16'hBEEF;
        cycle();
        tb_en = 1'b0; tb_we = 1'b0;
        set_core(3, 1'b1, 1'b0, 1'b0, 16'h0040, '0);
        cycle();
        chk("rd_gnt", 32'(obs_gnt), 32'(onehot(3)));
        core_req = '0;
        cycle();
        chk("rd_rvalid", 32'(obs_rvalid), 32'(onehot(3)));
        chk("rd_data", 32'(obs_rdata), 32'h0000BEEF);

        // Lock: move pointer to 2, then core 2 locks with 5 and 7 waiting.
        set_core(1, 1'b1, 1'b0, 1'b0, 16'h0001, '0);
        cycle();
        core_req = '0;
        set_core(2, 1'b1, 1'b1, 1'b1, 16'h0002, 16'h2222);
        set_core(5, 1'b1, 1'b0, 1'b0, 16'h0005, '0);
        set_core(7, 1'b1, 1'b0, 1'b0, 16'h0007, '0);
        for (int k = 0; k < LM; k++) begin
            cycle();
            chk("lock_gnt2", 32'(obs_gnt), 32'(onehot(2)));
        end
        cycle();
        chk("lock_gnt5", 32'(obs_gnt), 32'(onehot(5)));
        core_req[5] = 1'b0;
        cycle();
        chk("lock_gnt7", 32'(obs_gnt), 32'(onehot(7)));
        core_req[7] = 1'b0;
        cycle();
        chk("lock_regrant2", 32'(obs_gnt), 32'(onehot(2)));
        core_req = '0; core_lock = '0;
        cycle();

        // Lock release: core 2 drops lock on its 3rd grant; core 4 follows.
        set_core(9, 1'b1, 1'b0, 1'b0, 16'h0009, '0);
        cycle();
        core_req = '0;
        set_core(2, 1'b1, 1'b0, 1'b1, 16'h0003, '0);
        set_core(4, 1'b1, 1'b0, 1'b0, 16'h0004, '0);
        cycle();
        chk("rel_gnt2_a", 32'(obs_gnt), 32'(onehot(2)));
        cycle();
        chk("rel_gnt2_b", 32'(obs_gnt), 32'(onehot(2)));
        core_lock[2] = 1'b0;
        cycle();
        chk("rel_gnt2_last", 32'(obs_gnt), 32'(onehot(2)));
        cycle();
        chk("rel_gnt4", 32'(obs_gnt), 32'(onehot(4)));
        core_req = '0;
        cycle();

        // Testbench override while core 1 holds a lock.
        set_core(1, 1'b1, 1'b0, 1'b1, 16'h0020, '0);
        cycle();
        chk("ovr_lock_gnt1", 32'(obs_gnt), 32'(onehot(1)));
        tb_en = 1'b1; tb_we = 1'b1; tb_addr = 16'h0010; tb_wdata = 16'h1234;
        cycle();
        chk("ovr_gnt", 32'(obs_gnt), 32'd0);
        chk("ovr_mem_we", 32'(obs_we), 32'd1);
        chk("ovr_mem_addr", 32'(obs_addr), 32'h0010);
        chk("ovr_mem_wdata", 32'(obs_wdata), 32'h1234);
        tb_en = 1'b0; tb_we = 1'b0;
        set_core(3, 1'b1, 1'b0, 1'b0, 16'h0030, '0);
        cycle();
        chk("ovr_arb_gnt3", 32'(obs_gnt), 32'(onehot(3)));
        core_req[3] = 1'b0;
        tb_en = 1'b1; tb_we = 1'b0; tb_addr = 16'h0010;
        cycle();
        tb_en = 1'b0;
        cycle();
        chk("ovr_tb_rdata", 32'(obs_tb_rdata), 32'h1234);
        core_req = '0; core_lock = '0;
        cycle();

        // Reset mid-lock discards the pending read return.
        set_core(6, 1'b1, 1'b0, 1'b1, 16'h0040, '0);
        cycle();
        chk("mid_gnt6", 32'(obs_gnt), 32'(onehot(6)));
        RESET = 1'b1;
        #2;
        chk("mid_rst_rvalid", 32'(core_rvalid), 32'd0);
        chk("mid_rst_gnt", 32'(core_gnt), 32'd0);
        @(posedge clk); #1;
        RESET = 1'b0;
        model_reset();
        set_core(6, 1'b1, 1'b0, 1'b0, 16'h0040, '0);
        set_core(0, 1'b1, 1'b0, 1'b0, 16'h0000, '0);
        cycle();
        chk("post_rst_gnt0", 32'(obs_gnt), 32'(onehot(0)));
        core_req[0] = 1'b0;
        cycle();

        // Randomized traffic: cores hold requests until granted.
        core_req = '0; core_lock = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!core_req[i] || last_win == i) begin
                    set_core(i, ($urandom_range(0, 3) == 0), 1'($urandom),
                             ($urandom_range(0, 3) == 0),
                             AW'($urandom_range(0, 31)), DW'($urandom));
                end
            end
            tb_en    = ($urandom_range(0, 19) == 0);
            tb_we    = 1'($urandom);
            tb_addr  = AW'($urandom_range(0, 31));
            tb_wdata = DW'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
